led_frame_buffer: RTL and testbench

Parametrised double-buffered LED frame store sitting between the light-pen write path and the LED scan driver. The writer draws into a back bank while the scan driver reads a front bank. Bank swaps happen only on a driver frame boundary, so a partially drawn frame is never displayed. A sequential clear engine wipes the back bank without host loops.

---
 rtl/led_pkg.sv | 20 ++
 rtl/led_frame_buffer_if.sv | 48 ++++
 rtl/led_bank.sv | 34 +++
 rtl/led_frame_buffer.sv | 152 +++++++++++++++
 tb/tb_led_frame_buffer.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED frame buffer: pixel fields,
// reset pixel value and the clear-engine state encoding.
package led_pkg;

  localparam int PIX_STORED = 3;
  localparam int PIX_G      = 2;
  localparam int PIX_R      = 1;

  localparam logic [3:0] LED_RST_PIX = 4'b0000;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } fb_state_e;

  function automatic logic pix_lit(logic [3:0] p);
    return p[PIX_STORED] & (p[PIX_G] | p[PIX_R]);
  endfunction

endpackage

// File: rtl/led_frame_buffer_if.sv
// Host/scan-driver bundle of the LED frame buffer.
// master = writer + scan driver side, slave = frame buffer.
interface led_frame_buffer_if #(
  parameter int RA_W  = 3,
  parameter int CA_W  = 3,
  parameter int PIX_W = 4
);

  logic             wr_en;
  logic [RA_W-1:0]  wr_row;
  logic [CA_W-1:0]  wr_col;
  logic [PIX_W-1:0] wr_data;
  logic             wr_ready;

  logic             clr_req;
  logic             clr_busy;

  logic             swap_req;
  logic             swap_pend;
  logic             frame_start;
  logic             swap_done;

  logic             rd_en;
  logic [RA_W-1:0]  rd_row;
  logic [CA_W-1:0]  rd_col;
  logic [PIX_W-1:0] rd_data;
  logic             rd_valid;
  logic             front_sel;

  modport master (
    output wr_en, wr_row, wr_col, wr_data,
    output clr_req, swap_req, frame_start,
    output rd_en, rd_row, rd_col,
    input  wr_ready, clr_busy, swap_pend,
    input  swap_done, rd_data, rd_valid,
    input  front_sel
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_data,
    input  clr_req, swap_req, frame_start,
    input  rd_en, rd_row, rd_col,
    output wr_ready, clr_busy, swap_pend,
    output swap_done, rd_data, rd_valid,
    output front_sel
  );

endinterface

// File: rtl/led_bank.sv
// One pixel bank: flop storage, linear sync write port
// and linear combinational read port.
module led_bank
  import led_pkg::*;
#(
  parameter int               DEPTH   = 64,
  parameter int               AW      = 6,
  parameter int               PIX_W   = 4,
  parameter logic [PIX_W-1:0] RST_PIX = PIX_W'(LED_RST_PIX)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [PIX_W-1:0] rdata
);

  logic [PIX_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= RST_PIX;
      end
    end else if (we && (32'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = (32'(raddr) < DEPTH) ? mem[raddr] : '0;

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store with frame-aligned bank swap
// and a one-pixel-per-cycle clear engine on the back bank.
module led_frame_buffer
  import led_pkg::*;
#(
  parameter int               ROWS    = 8,
  parameter int               COLS    = 8,
  parameter int               PIX_W   = 4,
  parameter logic [PIX_W-1:0] RST_PIX = PIX_W'(LED_RST_PIX)
) (
  input logic               clk,
  input logic               rst_n,
  led_frame_buffer_if.slave bus
);

  localparam int RA_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CA_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int N    = ROWS * COLS;
  localparam int AW   = (N > 1) ? $clog2(N) : 1;

  fb_state_e        state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic             front_q, front_d;
  logic             pend_q, pend_d;
  logic             swap_fire;
  logic             clr_we, host_we;

  logic [RA_W-1:0]  wr_row, rd_row;
  logic [CA_W-1:0]  wr_col, rd_col;
  logic             wr_ok, rd_ok;
  logic [AW-1:0]    wr_idx, rd_idx;
  logic [AW-1:0]    bank_waddr;
  logic [PIX_W-1:0] bank_wdata;
  logic [1:0]       bank_we;
  logic [PIX_W-1:0] rd0, rd1;
  logic [PIX_W-1:0] rd_q;
  logic             rv_q;

  assign wr_row = bus.wr_row;
  assign wr_col = bus.wr_col;
  assign rd_row = bus.rd_row;
  assign rd_col = bus.rd_col;

  assign wr_ok  = (32'(wr_row) < ROWS) && (32'(wr_col) < COLS);
  assign rd_ok  = (32'(rd_row) < ROWS) && (32'(rd_col) < COLS);
  assign wr_idx = AW'(32'(wr_row) * COLS + 32'(wr_col));
  assign rd_idx = AW'(32'(rd_row) * COLS + 32'(rd_col));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      front_q <= front_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    front_d   = front_q;
    pend_d    = pend_q | bus.swap_req;
    swap_fire = 1'b0;
    clr_we    = 1'b0;
    host_we   = 1'b0;
    unique case (state_q)
      IDLE: begin
        swap_fire = (pend_q | bus.swap_req) & bus.frame_start;
        host_we   = bus.wr_en & wr_ok;
        if (swap_fire) begin
          front_d = ~front_q;
          pend_d  = 1'b0;
        end
        // A same-cycle clear lands on the bank that is back after the swap.
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == AW'(N - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
    endcase
  end

  assign bank_waddr = clr_we ? cnt_q : wr_idx;
  assign bank_wdata = clr_we ? RST_PIX : bus.wr_data;
  assign bank_we[0] = (clr_we | host_we) & front_q;
  assign bank_we[1] = (clr_we | host_we) & ~front_q;

  led_bank #(
    .DEPTH   (N),
    .AW      (AW),
    .PIX_W   (PIX_W),
    .RST_PIX (RST_PIX)
  ) u_bank0 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we[0]),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (rd_idx),
    .rdata (rd0)
  );

  led_bank #(
    .DEPTH   (N),
    .AW      (AW),
    .PIX_W   (PIX_W),
    .RST_PIX (RST_PIX)
  ) u_bank1 (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (bank_we[1]),
    .waddr (bank_waddr),
    .wdata (bank_wdata),
    .raddr (rd_idx),
    .rdata (rd1)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      rv_q <= 1'b0;
    end else begin
      rv_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_q <= rd_ok ? (front_q ? rd1 : rd0) : '0;
      end
    end
  end

  assign bus.wr_ready  = (state_q == IDLE);
  assign bus.clr_busy  = (state_q == CLEAR);
  assign bus.swap_pend = pend_q;
  assign bus.swap_done = swap_fire;
  assign bus.front_sel = front_q;
  assign bus.rd_data   = rd_q;
  assign bus.rd_valid  = rv_q;

endmodule

// File: tb/tb_led_frame_buffer.sv
// Randomized self-checking bench for led_frame_buffer: 8x8 main
// instance plus a 5x6 instance for range checks and non-zero RST_PIX.
module tb_led_frame_buffer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  led_frame_buffer_if #(.RA_W(3), .CA_W(3), .PIX_W(4)) bus8 ();
  led_frame_buffer_if #(.RA_W(3), .CA_W(3), .PIX_W(4)) bus5 ();

  led_frame_buffer #(.ROWS(8), .COLS(8), .PIX_W(4), .RST_PIX(4'b0000)) u_dut (
    .clk (clk), .rst_n (rst_n), .bus (bus8)
  );

  led_frame_buffer #(.ROWS(5), .COLS(6), .PIX_W(4), .RST_PIX(4'b1000)) u_sml (
    .clk (clk), .rst_n (rst_n), .bus (bus5)
  );

  int n_chk = 0;
  int n_fail = 0;

  // reference: two banks, index of the front one
  logic [3:0] mdl [2][64];
  int mfront = 0;

  function automatic int back_i();
    return 1 - mfront;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 64; i++) mdl[b][i] = 4'b0000;
    mfront = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus8.wr_en = 0; bus8.wr_row = 0; bus8.wr_col = 0; bus8.wr_data = 0;
    bus8.clr_req = 0; bus8.swap_req = 0; bus8.frame_start = 0;
    bus8.rd_en = 0; bus8.rd_row = 0; bus8.rd_col = 0;
    bus5.wr_en = 0; bus5.wr_row = 0; bus5.wr_col = 0; bus5.wr_data = 0;
    bus5.clr_req = 0; bus5.swap_req = 0; bus5.frame_start = 0;
    bus5.rd_en = 0; bus5.rd_row = 0; bus5.rd_col = 0;
  endtask

  task automatic wr(int r, int c, logic [3:0] d);
    bus8.wr_en = 1; bus8.wr_row = 3'(r); bus8.wr_col = 3'(c); bus8.wr_data = d;
    cyc();
    bus8.wr_en = 0;
    mdl[back_i()][r*8+c] = d;
  endtask

  task automatic rd(int r, int c, output logic [3:0] d, output logic v);
    bus8.rd_en = 1; bus8.rd_row = 3'(r); bus8.rd_col = 3'(c);
    cyc();
    d = bus8.rd_data; v = bus8.rd_valid;
    bus8.rd_en = 0;
  endtask

  task automatic rd5(int r, int c, output logic [3:0] d);
    bus5.rd_en = 1; bus5.rd_row = 3'(r); bus5.rd_col = 3'(c);
    cyc();
    d = bus5.rd_data;
    bus5.rd_en = 0;
  endtask

  task automatic do_swap();
    bus8.swap_req = 1; bus8.frame_start = 1;
    cyc();
    bus8.swap_req = 0; bus8.frame_start = 0;
    mfront = back_i();
  endtask

  task automatic scan_front(output int bad);
    logic [3:0] d; logic v;
    bad = 0;
    for (int i = 0; i < 64; i++) begin
      rd(i / 8, i % 8, d, v);
      if (d !== mdl[mfront][i] || v !== 1'b1) bad++;
    end
  endtask

  task automatic wait_clear(output int n);
    n = 0;
    while (bus8.clr_busy === 1'b1 && n < 300) begin
      n++;
      cyc();
    end
  endtask

  task automatic test_reset();
    logic [3:0] d; logic v; int bad;
    idle_inputs();
    model_reset();
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({bus8.wr_ready, bus8.clr_busy, bus8.swap_pend, bus8.swap_done,
         bus8.front_sel, bus8.rd_valid, bus8.rd_data} !== 10'b1_00000_0000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b want 1000000000",
        {bus8.wr_ready, bus8.clr_busy, bus8.swap_pend, bus8.swap_done,
         bus8.front_sel, bus8.rd_valid, bus8.rd_data});
    end
    cyc(); cyc();
    rst_n = 1;
    cyc();
    scan_front(bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL reset_front_scan: %0d bad pixels, want 0", bad);
    end
    rd(1, 1, d, v);
    n_chk++;
    if (v !== 1'b1) begin
      n_fail++; $display("FAIL rd_valid_rise: got %b want 1", v);
    end
    cyc();
    n_chk++;
    if (bus8.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_valid_fall: got %b want 0", bus8.rd_valid);
    end
  endtask

  task automatic test_swap();
    logic [3:0] d; logic v;
    wr(3, 5, 4'b1100);
    rd(3, 5, d, v);
    n_chk++;
    if (d !== 4'b0000) begin
      n_fail++; $display("FAIL pre_swap_read: got %b want 0000", d);
    end
    bus8.swap_req = 1; cyc(); bus8.swap_req = 0;
    n_chk++;
    if (bus8.swap_pend !== 1'b1) begin
      n_fail++; $display("FAIL swap_pend_set: got %b want 1", bus8.swap_pend);
    end
    cyc(); cyc(); cyc();
    bus8.frame_start = 1;
    bus8.rd_en = 1; bus8.rd_row = 3; bus8.rd_col = 5;
    #1;
    n_chk++;
    if (bus8.swap_done !== 1'b1) begin
      n_fail++; $display("FAIL swap_done_pulse: got %b want 1", bus8.swap_done);
    end
    cyc();
    bus8.frame_start = 0; bus8.rd_en = 0;
    mfront = back_i();
    #1;
    n_chk++;
    if ({bus8.front_sel, bus8.swap_pend, bus8.swap_done, bus8.rd_data} !== 7'b100_0000) begin
      n_fail++;
      $display("FAIL swap_exec: front/pend/done/rd got %b want 1000000",
        {bus8.front_sel, bus8.swap_pend, bus8.swap_done, bus8.rd_data});
    end
    rd(3, 5, d, v);
    n_chk++;
    if (d !== 4'b1100) begin
      n_fail++; $display("FAIL post_swap_read: got %b want 1100", d);
    end
    cyc(); cyc();
    n_chk++;
    if (bus8.rd_data !== 4'b1100 || bus8.rd_valid !== 1'b0) begin
      n_fail++; $display("FAIL rd_hold: got %b/%b want 1100/0", bus8.rd_data, bus8.rd_valid);
    end
  endtask

  task automatic test_random_rw();
    logic [3:0] d; logic v; int r, c, bad;
    bad = 0;
    for (int k = 0; k < 120; k++) begin
      r = int'($urandom_range(0, 7));
      c = int'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) begin
        wr(r, c, 4'($urandom));
      end else begin
        rd(r, c, d, v);
        if (d !== mdl[mfront][r*8+c]) bad++;
      end
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL random_front_reads: %0d bad, want 0", bad);
    end
    do_swap();
    scan_front(bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL random_swap_scan: %0d bad, want 0", bad);
    end
  endtask

  task automatic test_clear();
    int n, bad, rdy_bad;
    for (int i = 0; i < 64; i++) wr(i / 8, i % 8, 4'b1010);
    bus8.clr_req = 1; cyc(); bus8.clr_req = 0;
    bus8.wr_en = 1; bus8.wr_row = 1; bus8.wr_col = 1; bus8.wr_data = 4'hF;
    n = 0; rdy_bad = 0;
    while (bus8.clr_busy === 1'b1 && n < 300) begin
      if (bus8.wr_ready !== 1'b0) rdy_bad++;
      bus8.clr_req = (n == 5);
      n++;
      cyc();
    end
    bus8.wr_en = 0; bus8.clr_req = 0;
    for (int i = 0; i < 64; i++) mdl[back_i()][i] = 4'b0000;
    n_chk++;
    if (n !== 64) begin
      n_fail++; $display("FAIL clear_length: got %0d cycles want 64", n);
    end
    n_chk++;
    if (rdy_bad !== 0 || bus8.wr_ready !== 1'b1) begin
      n_fail++; $display("FAIL clear_wr_ready: %0d busy-cycles ready, end ready %b", rdy_bad, bus8.wr_ready);
    end
    do_swap();
    scan_front(bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL clear_scan: %0d bad, want 0", bad);
    end
  endtask

  task automatic test_swap_in_clear();
    int n, bad, f0;
    f0 = mfront;
    bus8.clr_req = 1; cyc(); bus8.clr_req = 0;
    for (int i = 0; i < 64; i++) mdl[back_i()][i] = 4'b0000;
    bus8.swap_req = 1; bus8.frame_start = 1;
    #1;
    n_chk++;
    if (bus8.swap_done !== 1'b0) begin
      n_fail++; $display("FAIL clear_swap_blocked: done got %b want 0", bus8.swap_done);
    end
    cyc();
    bus8.swap_req = 0; bus8.frame_start = 0;
    repeat (10) cyc();
    bus8.frame_start = 1; cyc(); bus8.frame_start = 0;
    wait_clear(n);
    n_chk++;
    if ({bus8.clr_busy, bus8.swap_pend, bus8.front_sel} !== {1'b0, 1'b1, 1'(f0)}) begin
      n_fail++;
      $display("FAIL clear_swap_pending: busy/pend/front got %b want 01%0d",
        {bus8.clr_busy, bus8.swap_pend, bus8.front_sel}, f0);
    end
    bus8.frame_start = 1;
    #1;
    n_chk++;
    if (bus8.swap_done !== 1'b1) begin
      n_fail++; $display("FAIL post_clear_swap_done: got %b want 1", bus8.swap_done);
    end
    cyc();
    bus8.frame_start = 0;
    mfront = back_i();
    n_chk++;
    if (bus8.front_sel !== 1'(mfront) || bus8.swap_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL post_clear_swap: front/pend got %b%b want %0d0",
        bus8.front_sel, bus8.swap_pend, mfront);
    end
    scan_front(bad);
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL post_clear_scan: %0d bad, want 0", bad);
    end
  endtask

  task automatic test_same_cycle();
    logic [3:0] d; logic v; int n, bad, ob;
    for (int k = 0; k < 16; k++) wr(k % 8, k / 2, 4'($urandom_range(1, 15)));
    do_swap();
    ob = back_i();
    bus8.swap_req = 1; bus8.frame_start = 1; bus8.clr_req = 1;
    bus8.wr_en = 1; bus8.wr_row = 2; bus8.wr_col = 6; bus8.wr_data = 4'b0111;
    cyc();
    idle_inputs();
    mdl[ob][22] = 4'b0111;
    mfront = ob;
    for (int i = 0; i < 64; i++) mdl[back_i()][i] = 4'b0000;
    n_chk++;
    if ({bus8.front_sel, bus8.clr_busy, bus8.swap_pend} !== {1'(mfront), 2'b10}) begin
      n_fail++;
      $display("FAIL same_cycle_state: front/busy/pend got %b want %0d10",
        {bus8.front_sel, bus8.clr_busy, bus8.swap_pend}, mfront);
    end
    rd(2, 6, d, v);
    n_chk++;
    if (d !== 4'b0111) begin
      n_fail++; $display("FAIL same_cycle_write: got %b want 0111", d);
    end
    wait_clear(n);
    n_chk++;
    if (n !== 63) begin
      n_fail++; $display("FAIL same_cycle_clear_len: got %0d want 63", n);
    end
    scan_front(bad);
    do_swap();
    scan_front(n);
    n_chk++;
    if (bad !== 0 || n !== 0) begin
      n_fail++; $display("FAIL same_cycle_scan: front %0d bad, cleared %0d bad, want 0/0", bad, n);
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0] d, exp; int bad;
    logic [3:0] m5 [30];
    for (int i = 0; i < 30; i++) m5[i] = 4'b1000;
    rd5(2, 3, d);
    n_chk++;
    if (d !== 4'b1000) begin
      n_fail++; $display("FAIL sml_reset_pix: got %b want 1000", d);
    end
    rd5(5, 0, d); exp = d;
    rd5(0, 6, d);
    n_chk++;
    if (exp !== 4'b0000 || d !== 4'b0000) begin
      n_fail++; $display("FAIL sml_oor_read: got %b/%b want 0000/0000", exp, d);
    end
    bus5.wr_en = 1; bus5.wr_data = 4'b1111;
    bus5.wr_row = 5; bus5.wr_col = 2; cyc();
    bus5.wr_row = 2; bus5.wr_col = 6; cyc();
    bus5.wr_row = 7; bus5.wr_col = 7; cyc();
    bus5.wr_row = 4; bus5.wr_col = 5; bus5.wr_data = 4'b0110; cyc();
    bus5.wr_en = 0;
    m5[29] = 4'b0110;
    bus5.swap_req = 1; bus5.frame_start = 1; cyc();
    bus5.swap_req = 0; bus5.frame_start = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      rd5(i / 6, i % 6, d);
      if (d !== m5[i]) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL sml_front_scan: %0d bad, want 0", bad);
    end
    bus5.swap_req = 1; bus5.frame_start = 1; cyc();
    bus5.swap_req = 0; bus5.frame_start = 0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      rd5(i / 6, i % 6, d);
      if (d !== 4'b1000) bad++;
    end
    n_chk++;
    if (bad !== 0) begin
      n_fail++; $display("FAIL sml_alias_scan: %0d bad, want 0", bad);
    end
  endtask

  task automatic test_reset_mid_clear();
    int bad, n;
    for (int k = 0; k < 8; k++) wr(k, 7 - k, 4'($urandom_range(1, 15)));
    do_swap();
    for (int k = 0; k < 8; k++) wr(k, k, 4'($urandom_range(1, 15)));
    bus8.clr_req = 1; cyc(); bus8.clr_req = 0;
    bus8.swap_req = 1; cyc(); bus8.swap_req = 0;
    repeat (18) cyc();
    n_chk++;
    if ({bus8.clr_busy, bus8.swap_pend} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_state: busy/pend got %b want 11",
        {bus8.clr_busy, bus8.swap_pend});
    end
    #2 rst_n = 0;
    #1;
    n_chk++;
    if ({bus8.clr_busy, bus8.swap_pend, bus8.front_sel, bus8.wr_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL mid_clear_reset: busy/pend/front/ready got %b want 0001",
        {bus8.clr_busy, bus8.swap_pend, bus8.front_sel, bus8.wr_ready});
    end
    cyc();
    rst_n = 1;
    cyc();
    model_reset();
    scan_front(bad);
    do_swap();
    scan_front(n);
    n_chk++;
    if (bad !== 0 || n !== 0) begin
      n_fail++; $display("FAIL post_reset_banks: %0d/%0d bad, want 0/0", bad, n);
    end
  endtask

  initial begin
    test_reset();
    test_swap();
    test_random_rw();
    test_clear();
    test_swap_in_clear();
    test_same_cycle();
    test_out_of_range();
    test_reset_mid_clear();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
